// File: rtl/traffic_timer_pkg.sv
// Shared definitions for the intersection phase timers: state encoding and
// second-count widths.
package traffic_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } timerState_t;

  localparam int SEC_W               = 7;
  localparam int DEFAULT_MAX_SECONDS = 99;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICKS_PER_SEC
// enabled cycles; holds its count while disabled.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_countdown_timer.sv
// Loads a phase duration in seconds, counts it down at 1 Hz with pause/hold,
// and reports the remaining time in binary and BCD plus an expiry pulse.
module phase_countdown_timer
  import traffic_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MAX_SECONDS   = DEFAULT_MAX_SECONDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SEC_W-1:0] loadTime,
  input  logic             pause,
  output logic [SEC_W-1:0] remaining,
  output logic [3:0]       remTens,
  output logic [3:0]       remOnes,
  output logic             busy,
  output logic             expired
);

  localparam logic [SEC_W-1:0] MAX_SEC = SEC_W'(MAX_SECONDS);

  timerState_t      state;
  logic             tick;
  logic [SEC_W-1:0] satLoad;

  function automatic logic [7:0] toBcd(input logic [SEC_W-1:0] value);
    return {4'(value / SEC_W'(10)), 4'(value % SEC_W'(10))};
  endfunction

  assign satLoad = (loadTime > MAX_SEC) ? MAX_SEC : loadTime;
  assign busy    = (state != ST_IDLE);
  assign {remTens, remOnes} = toBcd(remaining);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .enable((state == ST_RUN) && !pause && !load),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        state     <= ST_RUN;
        remaining <= satLoad;
      end else begin
        case (state)
          ST_RUN: begin
            // A zero-length load expires immediately, without waiting a tick.
            if (remaining == '0) begin
              state   <= ST_IDLE;
              expired <= 1'b1;
            end else if (pause) begin
              state <= ST_HOLD;
            end else if (tick) begin
              remaining <= remaining - SEC_W'(1);
              if (remaining == SEC_W'(1)) begin
                state   <= ST_IDLE;
                expired <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (!pause) state <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Self-checking bench for phase_countdown_timer: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_phase_countdown_timer;

  localparam int TICKS = 4;
  localparam int MAXS  = 99;

  logic       clk = 1'b0;
  logic       reset, load, pause;
  logic [6:0] loadTime;
  logic [6:0] remaining;
  logic [3:0] remTens, remOnes;
  logic       busy, expired;

  int checks = 0;
  int errors = 0;

  // Behavioural model: seconds left, cycles into the current second,
  // whether a countdown is live, and whether it is frozen by pause.
  int   mSecs = 0;
  int   mPhase = 0;
  bit   mActive = 0;
  bit   mFrozen = 0;
  bit   mExp = 0;
  logic prevExp = 1'b0;

  phase_countdown_timer #(
    .TICKS_PER_SEC(TICKS),
    .MAX_SECONDS  (MAXS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .loadTime (loadTime),
    .pause    (pause),
    .remaining(remaining),
    .remTens  (remTens),
    .remOnes  (remOnes),
    .busy     (busy),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [6:0] lt;
    logic       ps;
    logic [6:0] eRem;
    logic [3:0] eTens;
    logic [3:0] eOnes;
    logic       eBusy;
    logic       eExp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic rst, logic ld, logic [6:0] lt, logic ps,
                                 logic [6:0] eRem, logic [3:0] eTens,
                                 logic [3:0] eOnes, logic eBusy, logic eExp);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lt = lt; v.ps = ps;
    v.eRem = eRem; v.eTens = eTens; v.eOnes = eOnes;
    v.eBusy = eBusy; v.eExp = eExp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic ld, input logic [6:0] lt,
                           input logic ps);
    mExp = 0;
    if (rst) begin
      mSecs = 0; mPhase = 0; mActive = 0; mFrozen = 0;
    end else if (ld) begin
      mSecs = (int'(lt) > MAXS) ? MAXS : int'(lt);
      mPhase = 0; mActive = 1; mFrozen = 0;
    end else if (mActive) begin
      if (mFrozen) begin
        mFrozen = ps;
      end else if (mSecs == 0) begin
        mActive = 0; mExp = 1;
      end else if (ps) begin
        mFrozen = 1;
      end else begin
        mPhase++;
        if (mPhase == TICKS) begin
          mPhase = 0;
          mSecs--;
          if (mSecs == 0) begin
            mActive = 0; mExp = 1;
          end
        end
      end
    end
  endtask

  // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
  task automatic cycle(input logic rst, input logic ld, input logic [6:0] lt,
                       input logic ps, input string tag);
    logic [16:0] expVec;
    @(negedge clk);
    reset = rst; load = ld; loadTime = lt; pause = ps;
    modelStep(rst, ld, lt, ps);
    @(posedge clk);
    #1;
    expVec = {7'(mSecs), 4'(mSecs / 10), 4'(mSecs % 10), mActive, mExp};
    check({tag, "_model"}, 32'({remaining, remTens, remOnes, busy, expired}), 32'(expVec));
    check({tag, "_pulse"}, 32'(expired && prevExp), 32'(0));
    prevExp = expired;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'd0, 1'b0, tag);
  endtask

  int pulses;
  int pulseAt;

  initial begin
    reset = 1'b1; load = 1'b0; loadTime = '0; pause = 1'b0;

    // Vector table: inputs for the next edge, outputs expected after it.
    vecs.push_back(mkVec(1, 0, 7'd0,   0, 7'd0,  4'd0, 4'd0, 0, 0));
    vecs.push_back(mkVec(0, 1, 7'd120, 0, 7'd99, 4'd9, 4'd9, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd99, 4'd9, 4'd9, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd99, 4'd9, 4'd9, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd99, 4'd9, 4'd9, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd98, 4'd9, 4'd8, 1, 0));
    vecs.push_back(mkVec(0, 1, 7'd0,   0, 7'd0,  4'd0, 4'd0, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd0,  4'd0, 4'd0, 0, 1));
    vecs.push_back(mkVec(0, 0, 7'd0,   0, 7'd0,  4'd0, 4'd0, 0, 0));
    vecs.push_back(mkVec(0, 1, 7'd0,   1, 7'd0,  4'd0, 4'd0, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   1, 7'd0,  4'd0, 4'd0, 0, 1));
    vecs.push_back(mkVec(0, 1, 7'd100, 0, 7'd99, 4'd9, 4'd9, 1, 0));
    vecs.push_back(mkVec(0, 1, 7'd57,  0, 7'd57, 4'd5, 4'd7, 1, 0));
    vecs.push_back(mkVec(0, 1, 7'd7,   1, 7'd7,  4'd0, 4'd7, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   1, 7'd7,  4'd0, 4'd7, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   1, 7'd7,  4'd0, 4'd7, 1, 0));
    vecs.push_back(mkVec(0, 0, 7'd0,   1, 7'd7,  4'd0, 4'd7, 1, 0));
    vecs.push_back(mkVec(1, 1, 7'd9,   0, 7'd0,  4'd0, 4'd0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; load = vecs[i].ld; loadTime = vecs[i].lt; pause = vecs[i].ps;
      modelStep(vecs[i].rst, vecs[i].ld, vecs[i].lt, vecs[i].ps);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            32'({remaining, remTens, remOnes, busy, expired}),
            32'({vecs[i].eRem, vecs[i].eTens, vecs[i].eOnes, vecs[i].eBusy, vecs[i].eExp}));
      prevExp = expired;
    end

    // Load 3: decrements every 4 cycles, single expiry 12 cycles after load.
    cycle(1, 0, 7'd0, 0, "rst3");
    cycle(0, 1, 7'd3, 0, "load3");
    check("load3_rem", 32'(remaining), 32'(3));
    pulses = 0; pulseAt = -1;
    for (int k = 1; k <= 14; k++) begin
      cycle(0, 0, 7'd0, 0, "run3");
      if (expired) begin pulses++; pulseAt = k; end
      if (k == 4)  check("run3_rem_k4", 32'(remaining), 32'(2));
      if (k == 8)  check("run3_rem_k8", 32'(remaining), 32'(1));
      if (k == 11) check("run3_busy_k11", 32'(busy), 32'(1));
      if (k == 12) begin
        check("run3_rem_k12", 32'(remaining), 32'(0));
        check("run3_busy_k12", 32'(busy), 32'(0));
      end
    end
    check("run3_pulses", 32'(pulses), 32'(1));
    check("run3_pulse_at", 32'(pulseAt), 32'(12));

    // Load 5, run, pause 10 cycles, release: value frozen, partial second kept.
    cycle(0, 1, 7'd5, 0, "load5");
    idle(6, "run5");
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 7'd0, 1, "hold5");
      check("hold5_rem", 32'(remaining), 32'(4));
      check("hold5_busy", 32'(busy), 32'(1));
    end
    // Release edge only returns to RUN; prescaler held at 2 needs two more edges.
    cycle(0, 0, 7'd0, 0, "rel5");
    check("rel5_rem_r1", 32'(remaining), 32'(4));
    cycle(0, 0, 7'd0, 0, "rel5");
    check("rel5_rem_r2", 32'(remaining), 32'(4));
    cycle(0, 0, 7'd0, 0, "rel5");
    check("rel5_rem_r3", 32'(remaining), 32'(3));
    check("rel5_busy", 32'(busy), 32'(1));

    // Mid-count restart: aborted count never expires.
    cycle(0, 1, 7'd5, 0, "load5b");
    pulses = 0; pulseAt = -1;
    idle(5, "pre2");
    if (expired) pulses++;
    cycle(0, 1, 7'd2, 0, "load2");
    check("load2_rem", 32'(remaining), 32'(2));
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 7'd0, 0, "run2");
      if (expired) begin pulses++; pulseAt = k; end
    end
    check("run2_pulses", 32'(pulses), 32'(1));
    check("run2_pulse_at", 32'(pulseAt), 32'(8));

    // Load 0: expires on the very next edge.
    cycle(0, 1, 7'd0, 0, "load0");
    check("load0_busy", 32'(busy), 32'(1));
    cycle(0, 0, 7'd0, 0, "exp0");
    check("exp0_flags", 32'({busy, expired}), 32'(2'b01));
    check("exp0_rem", 32'(remaining), 32'(0));

    // Reset mid-count, then normal operation resumes.
    cycle(0, 1, 7'd4, 0, "load4");
    idle(3, "run4");
    cycle(1, 0, 7'd0, 0, "rst4");
    check("rst4_outputs", 32'({remaining, remTens, remOnes, busy, expired}), 32'(0));
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 7'd0, 0, "after_rst");
      if (expired) pulses++;
    end
    check("rst4_no_expiry", 32'(pulses), 32'(0));
    cycle(0, 1, 7'd2, 0, "reload2");
    check("reload2_rem", 32'(remaining), 32'(2));
    pulses = 0; pulseAt = -1;
    for (int k = 1; k <= 9; k++) begin
      cycle(0, 0, 7'd0, 0, "rerun2");
      if (expired) begin pulses++; pulseAt = k; end
    end
    check("reload2_pulse_at", 32'(pulseAt), 32'(8));

    // Randomized traffic against the model.
    begin
      logic rRst, rLd, rPs;
      logic [6:0] rLt;
      rPs = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        rRst = ($urandom_range(0, 199) == 0);
        rLd  = ($urandom_range(0, 29) == 0);
        case ($urandom_range(0, 3))
          0:       rLt = 7'd0;
          1:       rLt = 7'($urandom_range(96, 127));
          default: rLt = 7'($urandom_range(1, 6));
        endcase
        if ($urandom_range(0, 14) == 0) rPs = ~rPs;
        cycle(rRst, rLd, rLt, rPs, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_countdown_timer.md
Name: phase_countdown_timer

Overview:
- Downstream consumer of the pedestrian stage's `loadTime` (7-bit seconds value).
- Loads a phase duration, counts it down at 1 Hz from the system clock, and reports remaining seconds in binary and two-digit BCD for the crossing display.
- Emits a single-cycle `expired` pulse so the intersection controller can advance to its next phase.
- Supports pause, for example a night-time hold.

Parameters:
- TICKS_PER_SEC, 50000000, system clock cycles per one-second tick; minimum 2.
- MAX_SECONDS, 99, saturation limit applied to the loaded value; fits two BCD digits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  single-cycle request to start a new countdown.
- loadTime  input  7  duration in seconds, sampled only when load=1.
- pause  input  1  level; freezes countdown and prescaler while high.
- remaining  output  7  seconds left, binary.
- remTens  output  4  BCD tens digit of remaining.
- remOnes  output  4  BCD ones digit of remaining.
- busy  output  1  high in RUN or HOLD.
- expired  output  1  one-cycle pulse when the countdown reaches zero.

Behaviour:
- Reset, sampled at a clock edge:
  - state=IDLE, prescaler=0, remaining=0, remTens=0, remOnes=0, busy=0, expired=0.
  - Reset overrides every other input in the same cycle.
- States: IDLE, RUN, HOLD.
- Load, priority below reset and above everything else, accepted in any state:
  - remaining <= min(loadTime, MAX_SECONDS); prescaler <= 0; state <= RUN.
  - The new value is visible on `remaining` the cycle after the load edge.
  - A load during RUN or HOLD restarts the countdown and discards the old one; no `expired` is produced for the aborted count.
- Load with a value of 0:
  - State goes to RUN with remaining=0.
  - On the next edge: expired=1 for one cycle, state=IDLE.
  - No tick wait.
- RUN, pause=0:
  - prescaler increments each cycle.
  - When prescaler == TICKS_PER_SEC-1, a tick occurs: prescaler <= 0, remaining <= remaining-1.
- RUN, remaining transitions 1->0 on a tick:
  - On the same edge: state <= IDLE, expired <= 1.
  - expired drops on the following edge.
- RUN, pause=1: state <= HOLD; prescaler and remaining are held.
- HOLD:
  - pause=0 gives state <= RUN; the prescaler resumes from its held value, so partial-second progress is kept.
  - pause=1 stays in HOLD.
- IDLE:
  - remaining holds its last value (0 after expiry).
  - pause is ignored; busy=0.
- Load with pause=1 in the same cycle: load wins and the state goes to RUN. Pause takes effect on the next edge (RUN->HOLD). No tick is counted in that cycle.
- Outputs are registered:
  - busy = (state != IDLE), derived from the registered state.
  - expired is a registered pulse, never high for 2 consecutive cycles.
- BCD outputs:
  - remTens/remOnes are combinational from the registered `remaining`: tens = remaining/10, ones = remaining%10.
  - Valid because remaining <= 99 by saturation.
- Width rules:
  - prescaler width = clog2(TICKS_PER_SEC).
  - remaining never underflows; a decrement occurs only when remaining >= 1.
- The design contains no latches and no asynchronous paths.

Decomposition:
- Shared package `traffic_timer_pkg`:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2.
  - SEC_W=7.
  - default MAX_SECONDS.
- One sub-module, `tick_prescaler`:
  - Parameter TICKS_PER_SEC; inputs clk, reset, clear, enable; output tick (one cycle, combinational on terminal count).
  - Parent drives clear=load and enable=(state==RUN && !pause && !load).
- BIN-to-BCD conversion stays inline as a combinational function.

Test Plan (TICKS_PER_SEC=4):
- Reset, then load=1 with loadTime=3 for one cycle:
  - remaining=3 the next cycle, then 2, 1, 0 at 4-cycle intervals.
  - expired pulses exactly once, on the edge remaining reaches 0 (12 cycles after the load edge); busy falls at the same edge.
- Load loadTime=120:
  - remaining=99, remTens=9, remOnes=9.
  - First tick gives 98, with remTens=9 and remOnes=8.
- Load 5, run 6 cycles, pause for 10 cycles, release:
  - remaining stays 4 during the pause.
  - Decrement to 3 occurs 2 cycles after release.
  - busy stays 1 throughout.
- Load 5, wait 5 cycles, load 2 (mid-count restart):
  - remaining=2 the next cycle.
  - A single expired pulse occurs 8 cycles later; there is none for the aborted count.
- Load 0: expired=1 exactly one cycle after the load edge; remaining=0; state returns to IDLE.
- Load 4, assert reset mid-count:
  - Next cycle all outputs are 0 and state is IDLE.
  - expired is not asserted.
  - A subsequent load operates normally.
